// File: rtl/ha_array_pkg.sv
// ---------------------------------------------------------------------------
// ha_array_pkg
// Shared types and constants for the ha_array partial-product interface.
// The generator produces four half-adder-compressed groups. Each group has a
// 7-bit carry row (b) and a 9-bit sum row (t).
// No ports: this is a package only.
// ---------------------------------------------------------------------------
package ha_array_pkg;

    localparam int HA_B_W    = 7;
    localparam int HA_T_W    = 9;
    localparam int HA_GROUPS = 4;
    // Weighted value of one group: max 511 + 127*4 = 1019, so it fits in 11 bits.
    localparam int HA_G_W    = 11;

    typedef struct packed {
        logic [HA_B_W-1:0] b;
        logic [HA_T_W-1:0] t;
    } ha_group_t;

    typedef ha_group_t [HA_GROUPS-1:0] ha_set_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } acc_state_t;

endpackage

// File: rtl/ha_group_weigh.sv
// ---------------------------------------------------------------------------
// ha_group_weigh
// Combinational weighting of one compressed group.
// The result is G = sum t[k]<<k + sum b[k]<<(k+2).
// A carry b[k] comes from the pair at weight k+1, so it lands two places up.
// Ports:
//   grp    in   ha_group_t     carry/sum rows of one group
//   weight out  HA_G_W bits    group value before the 2g group offset
// ---------------------------------------------------------------------------
module ha_group_weigh
    import ha_array_pkg::*;
(
    input  ha_group_t          grp,
    output logic [HA_G_W-1:0]  weight
);

    always_comb begin
        weight = HA_G_W'(grp.t) + (HA_G_W'(grp.b) << 2);
    end

endmodule

// File: rtl/ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// ha_array_accumulator
// This block is the consumer end of the ha_array interface. It captures four
// compressed groups with a valid/ready handshake. It then adds one weighted
// group per cycle. Group g sits at offset 2g. The finished product is
// presented with a valid/ready handshake.
//
// Optional feature macro: HA_ACC_BIAS_EN
//   defined   -> the accumulator starts at BIAS and the result saturates
//                at 2^PROD_W-1.
//   undefined -> the accumulator starts at 0 and prod is the exact sum.
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   synchronous active-high reset
//   in_valid / in_ready in/out  input handshake (in_ready high only in IDLE)
//   ha_array_<g>_b      in   7-bit carry row of group g (g = 0..3)
//   ha_array_<g>_t      in   9-bit sum row of group g (g = 0..3)
//   out_valid/out_ready out/in  output handshake
//   prod                out  PROD_W-bit product, updated on entry to DONE
//   txn_cnt             out  8-bit completed-transaction count (wraps)
// ---------------------------------------------------------------------------
module ha_array_accumulator
    import ha_array_pkg::*;
#(
    parameter int PROD_W = 17,
    parameter int BIAS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HA_B_W-1:0] ha_array_0_b,
    input  logic [HA_T_W-1:0] ha_array_0_t,
    input  logic [HA_B_W-1:0] ha_array_1_b,
    input  logic [HA_T_W-1:0] ha_array_1_t,
    input  logic [HA_B_W-1:0] ha_array_2_b,
    input  logic [HA_T_W-1:0] ha_array_2_t,
    input  logic [HA_B_W-1:0] ha_array_3_b,
    input  logic [HA_T_W-1:0] ha_array_3_t,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] prod,
    output logic [7:0]        txn_cnt
);

`ifdef HA_ACC_BIAS_EN
    // The extra top bit only exists so that overflow past 2^PROD_W-1 can be seen.
    localparam int               ACC_W    = PROD_W + 1;
    localparam logic [ACC_W-1:0] ACC_INIT = ACC_W'(BIAS);
`else
    // Without a bias, the unbiased sum always fits in PROD_W bits.
    localparam int               ACC_W    = PROD_W;
    localparam logic [ACC_W-1:0] ACC_INIT = '0;

    if (BIAS != 0) begin : g_bias_needs_macro
        $error("BIAS is only honoured when HA_ACC_BIAS_EN is defined");
    end
`endif

    acc_state_t        state;
    acc_state_t        state_next;
    ha_set_t           in_set;
    ha_set_t           cap_set;
    logic [2:0]        idx;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  addend;
    logic [HA_G_W-1:0] weight;
    logic [PROD_W-1:0] prod_q;
    logic [7:0]        txn_q;

    // Gather the loose interface rows into one packed set for capture.
    always_comb begin
        in_set[0].b = ha_array_0_b;
        in_set[0].t = ha_array_0_t;
        in_set[1].b = ha_array_1_b;
        in_set[1].t = ha_array_1_t;
        in_set[2].b = ha_array_2_b;
        in_set[2].t = ha_array_2_t;
        in_set[3].b = ha_array_3_b;
        in_set[3].t = ha_array_3_t;
    end

    // A single weighting unit is shared by all groups and muxed by idx.
    ha_group_weigh u_weigh (
        .grp    (cap_set[idx[1:0]]),
        .weight (weight)
    );

    // Place the selected group at its 2*idx offset.
    always_comb begin
        addend = ACC_W'(weight) << {idx[1:0], 1'b0};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs. in_ready is forced low while
    // reset is asserted.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                // idx reaches 4 only after all four groups have been added.
                if (idx == 3'd4) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath.
    // - The set is captured in IDLE.
    // - One group is added per ACC cycle.
    // - The sum is moved to prod on the way into DONE.
    // - Transactions are counted when the output handshake completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_set <= '0;
            idx     <= '0;
            acc     <= '0;
            prod_q  <= '0;
            txn_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_set <= in_set;
                        acc     <= ACC_INIT;
                        idx     <= '0;
                    end
                end
                ACC: begin
                    if (idx != 3'd4) begin
                        acc <= acc + addend;
                        idx <= idx + 3'd1;
                    end else begin
`ifdef HA_ACC_BIAS_EN
                        prod_q <= acc[ACC_W-1] ? {PROD_W{1'b1}} : acc[PROD_W-1:0];
`else
                        prod_q <= acc;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        txn_q <= txn_q + 8'd1;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    assign prod    = prod_q;
    assign txn_cnt = txn_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ha_array_accumulator
// Self-checking bench for ha_array_accumulator.
// The cycle-timed reference model is checked every cycle:
// - A capture happens when in_valid is high and nothing is in flight.
// - The product appears 5 edges after the capture edge.
// - The product is held until out_ready is high.
// Directed transactions pin the model to hand-computed values.
// Honours HA_ACC_BIAS_EN (BIAS=100 in that build).
// ---------------------------------------------------------------------------
module tb_ha_array_accumulator;

    import ha_array_pkg::*;

    localparam int PROD_W  = 17;
    localparam int PROD_MAX = (1 << PROD_W) - 1;
`ifdef HA_ACC_BIAS_EN
    localparam int TB_BIAS = 100;
`else
    localparam int TB_BIAS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    ha_set_t           set_in = '0;
    logic              in_ready;
    logic              out_valid;
    logic [PROD_W-1:0] prod;
    logic [7:0]        txn_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model state: expected products and the edge each one was captured on.
    int exp_q[$];
    int cap_q[$];
    int model_prod = 0;
    int model_txn  = 0;
    bit exp_valid;
    bit exp_ready;

    ha_array_accumulator #(
        .PROD_W (PROD_W),
        .BIAS   (TB_BIAS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (set_in[0].b),
        .ha_array_0_t (set_in[0].t),
        .ha_array_1_b (set_in[1].b),
        .ha_array_1_t (set_in[1].t),
        .ha_array_2_b (set_in[2].b),
        .ha_array_2_t (set_in[2].t),
        .ha_array_3_b (set_in[3].b),
        .ha_array_3_t (set_in[3].t),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .prod         (prod),
        .txn_cnt      (txn_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference product: each set bit contributes its positional weight.
    function automatic int ref_prod(input ha_set_t s);
        int sum;
        sum = TB_BIAS;
        for (int g = 0; g < HA_GROUPS; g++) begin
            for (int k = 0; k < HA_T_W; k++)
                if (s[g].t[k]) sum += 1 << (k + 2 * g);
            for (int k = 0; k < HA_B_W; k++)
                if (s[g].b[k]) sum += 1 << (k + 2 + 2 * g);
        end
`ifdef HA_ACC_BIAS_EN
        if (sum > PROD_MAX) sum = PROD_MAX;
`endif
        return sum;
    endfunction

    function automatic ha_set_t rand_set();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return {$urandom(), $urandom()};
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cap_q.delete();
            model_prod = 0;
            model_txn  = 0;
            checkOutput("in_ready_during_reset", 32'(in_ready), 32'd0);
        end else begin
            exp_ready = (exp_q.size() == 0);
            exp_valid = !exp_ready && (cyc >= cap_q[0] + 5);
            if (!exp_ready && cyc == cap_q[0] + 5) model_prod = exp_q[0];
            checkOutput("mon_out_valid", 32'(out_valid), 32'(exp_valid));
            checkOutput("mon_in_ready", 32'(in_ready), 32'(exp_ready));
            checkOutput("mon_prod", 32'(prod), 32'(model_prod));
            checkOutput("mon_txn_cnt", 32'(txn_cnt), 32'(model_txn));
            if (exp_valid && out_ready) begin
                void'(exp_q.pop_front());
                void'(cap_q.pop_front());
                model_txn = (model_txn + 1) % 256;
            end
            if (exp_ready && in_valid) begin
                exp_q.push_back(ref_prod(set_in));
                cap_q.push_back(cyc + 1);
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction with out_ready held high. It then checks the model,
    // the product and the latency against a hand-computed literal.
    task automatic applyStimulus(input ha_set_t s, input int lit, input string name);
        bit got;
        int cap_cyc;
        checkOutput({name, "_model"}, 32'(ref_prod(s)), 32'(lit));
        set_in    = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        checkOutput({name, "_accepted"}, 32'(got), 32'd1);
        waitCycle();
        cap_cyc  = cyc;
        in_valid = 1'b0;
        set_in   = rand_set();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        checkOutput({name, "_valid_seen"}, 32'(got), 32'd1);
        checkOutput({name, "_latency"}, 32'(cyc - cap_cyc), 32'd5);
        checkOutput({name, "_prod"}, 32'(prod), 32'(lit));
        waitCycle();
    endtask

    initial begin
        ha_set_t s;
        ha_set_t set_a;
        ha_set_t set_b;
        bit got;
        int n_acc;
        int guard;
        bit acc_now;

        // Reset state.
        repeat (3) waitCycle();
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_prod", 32'(prod), 32'd0);
        checkOutput("reset_txn_cnt", 32'(txn_cnt), 32'd0);
        waitCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        waitCycle();

        // Single low bit of group 0.
        s = '0;
        s[0].t[0] = 1'b1;
        applyStimulus(s, 1 + TB_BIAS, "g0_t0");
        @(negedge clk);
        checkOutput("g0_t0_txn_cnt", 32'(txn_cnt), 32'd1);
        waitCycle();

        // Top sum bit of group 3.
        s = '0;
        s[3].t[8] = 1'b1;
        applyStimulus(s, 16384 + TB_BIAS, "g3_t8");

        // Reset asserted during the second ACC cycle.
        set_in    = rand_set();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        checkOutput("rst_mid_acc_accepted", 32'(got), 32'd1);
        waitCycle();
        in_valid = 1'b0;
        waitCycle();
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_acc_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_acc_prod", 32'(prod), 32'd0);
        checkOutput("rst_mid_acc_txn_cnt", 32'(txn_cnt), 32'd0);
        checkOutput("rst_mid_acc_in_ready", 32'(in_ready), 32'd1);
        waitCycle();

        // Fresh set after reset: MSB carry of group 1.
        s = '0;
        s[1].b[6] = 1'b1;
        applyStimulus(s, 1024 + TB_BIAS, "g1_b6");

        // All 64 bits set.
        applyStimulus('1, 86615 + TB_BIAS, "all_ones");

        // Output stall. in_valid is held with the next set, which must not be captured.
        set_a     = rand_set();
        set_b     = rand_set();
        set_in    = set_a;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        checkOutput("stall_accepted", 32'(got), 32'd1);
        waitCycle();
        set_in = set_b;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        checkOutput("stall_valid_seen", 32'(got), 32'd1);
        repeat (10) waitCycle();
        @(negedge clk);
        checkOutput("stall_prod_held", 32'(prod), 32'(ref_prod(set_a)));
        checkOutput("stall_out_valid_held", 32'(out_valid), 32'd1);
        checkOutput("stall_in_ready_low", 32'(in_ready), 32'd0);
        waitCycle();
        out_ready = 1'b1;
        waitCycle();
        @(negedge clk);
        checkOutput("stall_release_in_ready", 32'(in_ready), 32'd1);
        waitCycle();
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        checkOutput("stall_next_valid_seen", 32'(got), 32'd1);
        checkOutput("stall_next_prod", 32'(prod), 32'(ref_prod(set_b)));
        waitCycle();

        // 256 back-to-back random transactions after a reset. txn_cnt must wrap to 0.
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        set_in   = rand_set();
        in_valid = 1'b1;
        n_acc = 0;
        guard = 0;
        while (n_acc < 256 && guard < 20000) begin
            @(negedge clk);
            acc_now = in_ready && in_valid;
            waitCycle();
            guard++;
            if (acc_now) begin
                n_acc++;
                set_in = rand_set();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("random_all_accepted", 32'(n_acc), 32'd256);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        checkOutput("random_drained", 32'(got), 32'd1);
        checkOutput("random_txn_wrap", 32'(txn_cnt), 32'd0);

        repeat (2) waitCycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
